// File: rtl/bridge_utils_pkg.sv
// Shared types and encodings for the APB bridge scheduler: FSM states,
// burst encodings, response codes and grant bit positions.
package bridge_utils;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RDATA  = 3'd4,
        WDATA  = 3'd5,
        BRESP  = 3'd6
    } sched_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_RD = 0;
    localparam int GNT_WR = 1;

endpackage

// File: rtl/bridge_rw_arbiter.sv
// Read/write request arbiter producing a one-hot grant while i_grant_en is high.
// BRIDGE_RR_ARB_EN selects round-robin; otherwise reads have fixed priority.
module bridge_rw_arbiter
    import bridge_utils::*;
(
`ifdef BRIDGE_RR_ARB_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       i_rd_valid,
    input  logic       i_wr_valid,
    input  logic       i_grant_en,
    output logic [1:0] o_grant
);

`ifdef BRIDGE_RR_ARB_EN
    // 1 = write is preferred on the next simultaneous request.
    logic r_ptr_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_wr <= 1'b0;
        end else if (|o_grant) begin
            r_ptr_wr <= o_grant[GNT_RD];
        end
    end

    always_comb begin
        o_grant = 2'b00;
        if (i_grant_en) begin
            if (i_rd_valid && i_wr_valid) begin
                if (r_ptr_wr) o_grant[GNT_WR] = 1'b1;
                else          o_grant[GNT_RD] = 1'b1;
            end else if (i_rd_valid) begin
                o_grant[GNT_RD] = 1'b1;
            end else if (i_wr_valid) begin
                o_grant[GNT_WR] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        o_grant = 2'b00;
        if (i_grant_en) begin
            if (i_rd_valid)      o_grant[GNT_RD] = 1'b1;
            else if (i_wr_valid) o_grant[GNT_WR] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/bridge_apb_scheduler.sv
// Serialises read/write bursts onto an APB master, one APB transfer per beat.
// Define BRIDGE_RR_ARB_EN for round-robin arbitration (default: reads win).
module bridge_apb_scheduler
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // Every valid/ready pair transfers on a rising edge where both are 1;
    // the bridge keeps its valids and payloads stable until accepted.
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]            rd_len,
    input  logic [2:0]            rd_size,
    input  logic [1:0]            rd_burst,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [3:0]            wr_len,
    input  logic [2:0]            wr_size,
    input  logic [1:0]            wr_burst,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rdata_resp,
    output logic                  rdata_last,
    input  logic                  rdata_ready,
    output logic                  bresp_valid,
    output logic [1:0]            bresp,
    input  logic                  bresp_ready,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output sched_state_t          o_dbg_state
);

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [3:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic                  r_err;
    logic [1:0]            w_grant;
    logic                  w_last;

    bridge_rw_arbiter u_arb (
`ifdef BRIDGE_RR_ARB_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .i_rd_valid (rd_req_valid),
        .i_wr_valid (wr_req_valid),
        .i_grant_en (r_state == ARB),
        .o_grant    (w_grant)
    );

    assign w_last      = (r_cnt == 4'd0);
    assign paddr       = r_addr;
    assign pwrite      = r_write;
    assign pwdata      = r_pwdata;
    assign rdata       = r_rdata;
    assign rdata_resp  = r_resp;
    assign o_dbg_state = r_state;

    // WRAP bursts deliberately advance like INCR.
    always_comb begin
        w_addr_next = r_addr + (ADDR_WIDTH'(1) << r_size);
        case (r_burst)
            BURST_FIXED:            w_addr_next = r_addr;
            BURST_INCR, BURST_WRAP: w_addr_next = r_addr + (ADDR_WIDTH'(1) << r_size);
            default:                w_addr_next = r_addr + (ADDR_WIDTH'(1) << r_size);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        wdata_ready  = 1'b0;
        rdata_valid  = 1'b0;
        rdata_last   = 1'b0;
        bresp_valid  = 1'b0;
        bresp        = RESP_OKAY;
        psel         = 1'b0;
        penable      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req_valid || wr_req_valid) w_next = ARB;
            end
            ARB: begin
                if (w_grant[GNT_WR]) begin
                    wr_req_ready = 1'b1;
                    w_next       = WDATA;
                end else if (w_grant[GNT_RD]) begin
                    rd_req_ready = 1'b1;
                    w_next       = SETUP;
                end else begin
                    w_next = IDLE;
                end
            end
            WDATA: begin
                wdata_ready = 1'b1;
                if (wdata_valid) w_next = SETUP;
            end
            SETUP: begin
                psel   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    if (!r_write)    w_next = RDATA;
                    else if (w_last) w_next = BRESP;
                    else             w_next = WDATA;
                end
            end
            RDATA: begin
                rdata_valid = 1'b1;
                rdata_last  = w_last;
                if (rdata_ready) w_next = w_last ? IDLE : SETUP;
            end
            BRESP: begin
                bresp_valid = 1'b1;
                bresp       = r_err ? RESP_SLVERR : RESP_OKAY;
                if (bresp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_cnt    <= 4'd0;
            r_size   <= 3'd0;
            r_burst  <= 2'b00;
            r_write  <= 1'b0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_resp   <= RESP_OKAY;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_grant[GNT_WR]) begin
                        r_addr  <= wr_addr;
                        r_cnt   <= wr_len;
                        r_size  <= wr_size;
                        r_burst <= wr_burst;
                        r_write <= 1'b1;
                    end else if (w_grant[GNT_RD]) begin
                        r_addr  <= rd_addr;
                        r_cnt   <= rd_len;
                        r_size  <= rd_size;
                        r_burst <= rd_burst;
                        r_write <= 1'b0;
                    end
                end
                WDATA: begin
                    if (wdata_valid) r_pwdata <= wdata;
                end
                ACCESS: begin
                    if (pready) begin
                        if (!r_write) begin
                            r_rdata <= prdata;
                            r_resp  <= pslverr ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            r_err <= r_err | pslverr;
                            if (!w_last) begin
                                r_cnt  <= r_cnt - 4'd1;
                                r_addr <= w_addr_next;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (rdata_ready && !w_last) begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_addr <= w_addr_next;
                    end
                end
                BRESP: begin
                    if (bresp_ready) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_apb_scheduler.sv
// Directed bench for bridge_apb_scheduler: APB slave model, transaction log
// scoreboard and hand-computed expectations; BRIDGE_RR_ARB_EN picks arbitration expectations.
module tb_bridge_apb_scheduler;
  import bridge_utils::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req_valid = 1'b0, rd_req_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [3:0] rd_len = '0;
  logic [2:0] rd_size = '0;
  logic [1:0] rd_burst = '0;
  logic wr_req_valid = 1'b0, wr_req_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0] wr_len = '0;
  logic [2:0] wr_size = '0;
  logic [1:0] wr_burst = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic rdata_valid, rdata_last;
  logic rdata_ready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0] rdata_resp;
  logic bresp_valid;
  logic bresp_ready = 1'b0;
  logic [1:0] bresp;
  logic psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic pready = 1'b0;
  logic pslverr = 1'b0;
  sched_state_t dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  bridge_apb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_size(rd_size), .rd_burst(rd_burst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_size(wr_size), .wr_burst(wr_burst),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_resp(rdata_resp),
    .rdata_last(rdata_last), .rdata_ready(rdata_ready),
    .bresp_valid(bresp_valid), .bresp(bresp), .bresp_ready(bresp_ready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return 32'hA5A5A5A5 + (a - 32'h100);
  endfunction

  // APB slave model: pready after slv_wait low ACCESS cycles
  int slv_wait = 0;
  int slv_cnt = 0;
  logic slv_err_en = 1'b0;
  logic [AW-1:0] slv_err_addr = '0;

  always @(negedge clk) begin
    if (psel && penable) begin
      pready  = (slv_cnt >= slv_wait);
      pslverr = pready && slv_err_en && (paddr == slv_err_addr);
      prdata  = exp_rd(paddr);
      slv_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      slv_cnt = 0;
    end
  end

  // scoreboard: completed APB transfers against expected queues
  logic [AW-1:0] apb_addr_q[$];
  logic          apb_wr_q[$];
  logic [DW-1:0] apb_wdata_q[$];
  logic [AW-1:0] exp_q[$];
  logic          exp_wr_q[$];
  logic [DW-1:0] exp_wdata_q[$];

  always @(posedge clk) begin
    if (!rst && psel && penable && pready) begin
      apb_addr_q.push_back(paddr);
      apb_wr_q.push_back(pwrite);
      apb_wdata_q.push_back(pwdata);
    end
  end

  // APB stability monitor across SETUP/ACCESS
  int stab_err = 0;
  int acc_cycles = 0;
  logic prev_psel = 1'b0, prev_pwrite = 1'b0;
  logic [AW-1:0] prev_paddr = '0;
  logic [DW-1:0] prev_pwdata = '0;

  always @(negedge clk) begin
    if (psel && prev_psel &&
        (paddr !== prev_paddr || pwrite !== prev_pwrite || pwdata !== prev_pwdata))
      stab_err++;
    if (psel && penable) acc_cycles++;
    prev_psel = psel; prev_paddr = paddr; prev_pwrite = pwrite; prev_pwdata = pwdata;
  end

  task automatic expect_apb(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    exp_q.push_back(a);
    exp_wr_q.push_back(w);
    exp_wdata_q.push_back(d);
  endtask

  task automatic check_apb(input string tag);
    int n;
    check_eq({tag, "_apb_count"}, apb_addr_q.size(), exp_q.size());
    n = (apb_addr_q.size() < exp_q.size()) ? apb_addr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_paddr"}, apb_addr_q[i], exp_q[i]);
      check_eq({tag, "_pwrite"}, apb_wr_q[i], exp_wr_q[i]);
      if (exp_wr_q[i]) check_eq({tag, "_pwdata"}, apb_wdata_q[i], exp_wdata_q[i]);
    end
    apb_addr_q.delete(); apb_wr_q.delete(); apb_wdata_q.delete();
    exp_q.delete(); exp_wr_q.delete(); exp_wdata_q.delete();
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic wait_grant(output logic [1:0] g);
    logic got;
    got = 1'b0;
    g = 2'b00;
    for (int i = 0; i < 50; i++) begin
      if (rd_req_ready || wr_req_ready) begin
        got = 1'b1;
        g = {wr_req_ready, rd_req_ready};
        break;
      end
      @(negedge clk);
    end
    check_eq("grant_seen", got, 1'b1);
    if (got) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("req_ready_one_cycle", {wr_req_ready, rd_req_ready}, 2'b00);
    end
  endtask

  task automatic req_read(input logic [AW-1:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    logic [1:0] g;
    rd_addr = a; rd_len = l; rd_size = s; rd_burst = b; rd_req_valid = 1'b1;
    wait_grant(g);
    rd_req_valid = 1'b0;
    check_eq("rd_grant", g, 2'b01);
  endtask

  task automatic req_write(input logic [AW-1:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [1:0] b);
    logic [1:0] g;
    wr_addr = a; wr_len = l; wr_size = s; wr_burst = b; wr_req_valid = 1'b1;
    wait_grant(g);
    wr_req_valid = 1'b0;
    check_eq("wr_grant", g, 2'b10);
  endtask

  task automatic recv_rbeat(input logic [DW-1:0] d, input logic [1:0] r, input logic l,
                            input int hold);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rdata_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("rdata_valid_seen", got, 1'b1);
    check_eq("rdata", rdata, d);
    check_eq("rdata_resp", rdata_resp, r);
    check_eq("rdata_last", rdata_last, l);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("rdata_hold", {rdata_valid, rdata_last, rdata_resp, rdata}, {1'b1, l, r, d});
    end
    rdata_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdata_ready = 1'b0;
  endtask

  task automatic send_wbeat(input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wdata_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("wdata_ready_seen", got, 1'b1);
    wdata_valid = 1'b1; wdata = d;
    @(posedge clk);
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic recv_bresp(input logic [1:0] r);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bresp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("bresp_valid_seen", got, 1'b1);
    check_eq("bresp", bresp, r);
    bresp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bresp_ready = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctrl"}, {psel, penable, pwrite, rd_req_ready, wr_req_ready, wdata_ready,
                              rdata_valid, rdata_last, bresp_valid}, 9'd0);
    check_eq({tag, "_data"}, {paddr, pwdata}, 64'd0);
    check_eq({tag, "_rdata"}, {rdata_resp, bresp, rdata}, 36'd0);
    check_eq({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    logic [1:0] g;
    logic extra;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_after_reset", dbg_state, IDLE);

    // single read 0x100
    expect_apb(32'h100, 1'b0, '0);
    req_read(32'h100, 4'd0, 3'd2, BURST_INCR);
    recv_rbeat(32'hA5A5A5A5, RESP_OKAY, 1'b1, 0);
    check_apb("single_rd");

    // write INCR 0x200 len 3 size 2
    req_write(32'h200, 4'd3, 3'd2, BURST_INCR);
    for (int k = 0; k < 4; k++) begin
      expect_apb(32'h200 + 4 * k, 1'b1, 32'h1111_0000 + k);
      send_wbeat(32'h1111_0000 + k);
    end
    recv_bresp(RESP_OKAY);
    check_apb("incr_wr");

    // simultaneous requests, read persisting
    rd_addr = 32'h300; rd_len = 4'd0; rd_size = 3'd2; rd_burst = BURST_INCR;
    wr_addr = 32'h400; wr_len = 4'd0; wr_size = 3'd2; wr_burst = BURST_INCR;
    rd_req_valid = 1'b1; wr_req_valid = 1'b1;
    wait_grant(g);
    check_eq("both_grant1", g, 2'b01);
    expect_apb(32'h300, 1'b0, '0);
    recv_rbeat(exp_rd(32'h300), RESP_OKAY, 1'b1, 0);
    wait_grant(g);
`ifdef BRIDGE_RR_ARB_EN
    check_eq("both_grant2_rr", g, 2'b10);
    wr_req_valid = 1'b0;
    expect_apb(32'h400, 1'b1, 32'hCAFE_0001);
    send_wbeat(32'hCAFE_0001);
    recv_bresp(RESP_OKAY);
    wait_grant(g);
    rd_req_valid = 1'b0;
    check_eq("both_grant3_rr", g, 2'b01);
    expect_apb(32'h300, 1'b0, '0);
    recv_rbeat(exp_rd(32'h300), RESP_OKAY, 1'b1, 0);
`else
    check_eq("both_grant2_fixed", g, 2'b01);
    rd_req_valid = 1'b0;
    expect_apb(32'h300, 1'b0, '0);
    recv_rbeat(exp_rd(32'h300), RESP_OKAY, 1'b1, 0);
    wait_grant(g);
    wr_req_valid = 1'b0;
    check_eq("both_grant3_fixed", g, 2'b10);
    expect_apb(32'h400, 1'b1, 32'hCAFE_0001);
    send_wbeat(32'hCAFE_0001);
    recv_bresp(RESP_OKAY);
`endif
    check_apb("simul");

    // pslverr on beat 0 of a two-beat write, then sticky error cleared
    slv_err_en = 1'b1; slv_err_addr = 32'h500;
    req_write(32'h500, 4'd1, 3'd2, BURST_INCR);
    expect_apb(32'h500, 1'b1, 32'hBEEF_0000);
    send_wbeat(32'hBEEF_0000);
    expect_apb(32'h504, 1'b1, 32'hBEEF_0001);
    send_wbeat(32'hBEEF_0001);
    recv_bresp(RESP_SLVERR);
    slv_err_en = 1'b0;
    req_write(32'h508, 4'd0, 3'd2, BURST_INCR);
    expect_apb(32'h508, 1'b1, 32'hBEEF_0002);
    send_wbeat(32'hBEEF_0002);
    recv_bresp(RESP_OKAY);
    check_apb("slverr_wr");

    // read with pslverr
    slv_err_en = 1'b1; slv_err_addr = 32'h520;
    expect_apb(32'h520, 1'b0, '0);
    req_read(32'h520, 4'd0, 3'd2, BURST_INCR);
    recv_rbeat(exp_rd(32'h520), RESP_SLVERR, 1'b1, 0);
    slv_err_en = 1'b0;
    check_apb("slverr_rd");

    // pready low 5 cycles, rdata_ready low 3 cycles
    slv_wait = 5; stab_err = 0; acc_cycles = 0;
    expect_apb(32'h600, 1'b0, '0);
    expect_apb(32'h604, 1'b0, '0);
    req_read(32'h600, 4'd1, 3'd2, BURST_INCR);
    recv_rbeat(exp_rd(32'h600), RESP_OKAY, 1'b0, 3);
    recv_rbeat(exp_rd(32'h604), RESP_OKAY, 1'b1, 3);
    check_eq("stall_apb_stable", stab_err, 0);
    check_eq("stall_access_cycles", acc_cycles, 12);
    check_apb("stall");
    slv_wait = 0;

    // FIXED burst keeps address
    req_read(32'h700, 4'd2, 3'd2, BURST_FIXED);
    for (int k = 0; k < 3; k++) begin
      expect_apb(32'h700, 1'b0, '0);
      recv_rbeat(32'hA5A5ABA5, RESP_OKAY, (k == 2), 0);
    end
    check_apb("fixed");

    // len 15: sixteen byte-sized beats
    req_read(32'h800, 4'd15, 3'd0, BURST_INCR);
    for (int k = 0; k < 16; k++) begin
      expect_apb(32'h800 + k, 1'b0, '0);
      recv_rbeat(exp_rd(32'h800 + k), RESP_OKAY, (k == 15), 0);
    end
    check_apb("len15");

    // address wraps modulo 2^32
    req_read(32'hFFFF_FFFC, 4'd1, 3'd2, BURST_WRAP);
    expect_apb(32'hFFFF_FFFC, 1'b0, '0);
    expect_apb(32'h0, 1'b0, '0);
    recv_rbeat(exp_rd(32'hFFFF_FFFC), RESP_OKAY, 1'b0, 0);
    recv_rbeat(exp_rd(32'h0), RESP_OKAY, 1'b1, 0);
    check_apb("addr_wrap");

    // reset during ACCESS of beat 2 of a 4-beat read
    expect_apb(32'h900, 1'b0, '0);
    expect_apb(32'h904, 1'b0, '0);
    req_read(32'h900, 4'd3, 3'd2, BURST_INCR);
    recv_rbeat(exp_rd(32'h900), RESP_OKAY, 1'b0, 0);
    recv_rbeat(exp_rd(32'h904), RESP_OKAY, 1'b0, 0);
    slv_wait = 20;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_access", {psel, penable, paddr}, {2'b11, 32'h908});
    #1 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    slv_wait = 0;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdata_valid || bresp_valid || psel) extra = 1'b1;
    end
    check_eq("no_resp_after_reset", extra, 1'b0);
    check_apb("reset_mid");
    expect_apb(32'h100, 1'b0, '0);
    req_read(32'h100, 4'd0, 3'd2, BURST_INCR);
    recv_rbeat(32'hA5A5A5A5, RESP_OKAY, 1'b1, 0);
    check_apb("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
